// File: rtl/cycle_gen_pkg.sv
// cycle_gen_pkg: cycle-vector bit positions and the shared sequencer state type.
// The CYCLE_* macros give the width of the one-hot cycle vector and the bit
// that marks each active phase. WAIT and HALT have no bit of their own.
// Optional feature macro used by cycle_gen: CYCLE_GEN_STEP_EN.
`ifndef CYCLE_GEN_CONSTANTS
`define CYCLE_GEN_CONSTANTS
`define CYCLE_SIZE   3
`define CYCLE_FETCH  0
`define CYCLE_DECODE 1
`define CYCLE_EXEC   2
`endif

package cycle_gen_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } cycle_state_t;

  // Phase vector seen by the PC, register file and decoder; zero in WAIT/HALT.
  function automatic logic [`CYCLE_SIZE-1:0] cycle_onehot(cycle_state_t s);
    logic [`CYCLE_SIZE-1:0] v;
    v = '0;
    case (s)
      ST_FETCH:  v[`CYCLE_FETCH]  = 1'b1;
      ST_DECODE: v[`CYCLE_DECODE] = 1'b1;
      ST_EXEC:   v[`CYCLE_EXEC]   = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cycle_gen_wait_timer.sv
// wait_timer: counts cycles spent in WAIT.
// clr restarts the count from zero; it is asserted on the cycle before WAIT is
// entered. en is high while in WAIT. expired flags the last WAIT cycle allowed
// before a timeout.
module wait_timer #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int TW           = $clog2(WAIT_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Expiry comes from the count of WAIT cycles that are already complete.
  assign expired = en && (cnt_q == TW'(WAIT_TIMEOUT - 1));

  // Next count. It holds at the expiry value so it cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cycle_gen.sv
// cycle_gen: instruction-cycle sequencer for the picoMIPS core.
// It drives the one-hot cycle vector (FETCH/DECODE/EXEC). It stretches
// execution through a start/done handshake with multi-cycle units, and it
// handles halt/resume and the WAIT timeout fault. It also counts retired
// instructions.
// Optional feature: CYCLE_GEN_STEP_EN adds step_mode/step single-stepping.
module cycle_gen
  import cycle_gen_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   multi_cycle,
  input  logic                   unit_done,
  input  logic                   halt_instr,
  input  logic                   branch_req,
  input  logic                   cond_flag,
  input  logic                   resume,
  output logic [`CYCLE_SIZE-1:0] cycle,
  output logic                   branch,
  output logic                   unit_start,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_WIDTH-1:0]   retired
`ifdef CYCLE_GEN_STEP_EN
  ,
  input  logic                   step_mode,
  input  logic                   step
`endif
);

  cycle_state_t           state_q, state_d;
  logic [`CYCLE_SIZE-1:0] cycle_q, cycle_d;
  logic                   unit_start_q, unit_start_d;
  logic                   halted_q, halted_d;
  logic                   fault_q, fault_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;
  logic stop_exec;
  logic leave_halt;

`ifdef CYCLE_GEN_STEP_EN
  assign stop_exec  = halt_instr | step_mode;
  assign leave_halt = resume | step;
`else
  assign stop_exec  = halt_instr;
  assign leave_halt = resume;
`endif

  assign timer_clr = (state_q == ST_DECODE) && multi_cycle;
  assign timer_en  = (state_q == ST_WAIT);

  wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = multi_cycle ? ST_WAIT : ST_EXEC;
      ST_WAIT: begin
        // A done in the same cycle as expiry still counts as completion.
        if (unit_done) begin
          state_d = ST_EXEC;
        end else if (timer_expired) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      ST_EXEC: begin
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = stop_exec ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        // A faulted core stays in HALT until reset.
        if (leave_halt && !fault_q) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    cycle_d      = cycle_onehot(state_d);
    unit_start_d = (state_d == ST_WAIT) && (state_q != ST_WAIT);
    halted_d     = (state_d == ST_HALT);
  end

  // Sequencer state and the outputs registered with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      cycle_q      <= cycle_onehot(ST_FETCH);
      unit_start_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      unit_start_q <= unit_start_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
      retired_q    <= retired_d;
    end
  end

  assign cycle      = cycle_q;
  assign unit_start = unit_start_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign retired    = retired_q;
  assign branch     = branch_req && cond_flag && (state_q == ST_EXEC);

endmodule

// File: tb/tb_cycle_gen.sv
// tb_cycle_gen: directed bench for cycle_gen. WAIT_TIMEOUT is 4 and the
// retired counter is 4 bits wide. Expected outputs for each cycle are queued
// when that cycle's inputs are driven, then popped and compared mid-cycle.
module tb_cycle_gen;

  localparam logic [2:0] F = 3'b001;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] E = 3'b100;
  localparam logic [2:0] Z = 3'b000;

  logic       clk = 1'b0;
  logic       reset, multi_cycle, unit_done, halt_instr;
  logic       branch_req, cond_flag, resume;
  logic [2:0] cycle;
  logic       branch, unit_start, halted, fault;
  logic [3:0] retired;
`ifdef CYCLE_GEN_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] cyc;
    logic       st;
    logic       hl;
    logic       ft;
    logic       br;
    logic [3:0] ret;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   step_no = 0;

  cycle_gen #(
    .WAIT_TIMEOUT (4),
    .CNT_WIDTH    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .multi_cycle (multi_cycle),
    .unit_done   (unit_done),
    .halt_instr  (halt_instr),
    .branch_req  (branch_req),
    .cond_flag   (cond_flag),
    .resume      (resume),
    .cycle       (cycle),
    .branch      (branch),
    .unit_start  (unit_start),
    .halted      (halted),
    .fault       (fault),
    .retired     (retired)
`ifdef CYCLE_GEN_STEP_EN
    ,
    .step_mode   (step_mode),
    .step        (step)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
  endtask

  // One clock cycle: drive inputs, queue expected outputs, compare, advance.
  task automatic cyc(input logic mc, input logic ud, input logic hi,
                     input logic brq, input logic cf, input logic rs, input logic rst,
                     input logic [2:0] e_cyc, input logic e_st, input logic e_hl,
                     input logic e_ft, input logic e_br, input logic [3:0] e_ret);
    exp_t e;
    multi_cycle = mc;
    unit_done   = ud;
    halt_instr  = hi;
    branch_req  = brq;
    cond_flag   = cf;
    resume      = rs;
    reset       = rst;
    sb.push_back('{e_cyc, e_st, e_hl, e_ft, e_br, e_ret});
    #1;
    e = sb.pop_front();
    step_no++;
    chk("cycle",      {1'b0, cycle}, {1'b0, e.cyc});
    chk("unit_start", {3'b0, unit_start}, {3'b0, e.st});
    chk("halted",     {3'b0, halted}, {3'b0, e.hl});
    chk("fault",      {3'b0, fault}, {3'b0, e.ft});
    chk("branch",     {3'b0, branch}, {3'b0, e.br});
    chk("retired",    retired, e.ret);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; multi_cycle = 1'b0; unit_done = 1'b0; halt_instr = 1'b0;
    branch_req = 1'b0; cond_flag = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then three plain instructions.
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'(i));
      cyc(0,0,0,0,0,0,0, D,0,0,0,0, 4'(i));
      cyc(0,0,0,0,0,0,0, E,0,0,0,0, 4'(i));
    end

    // Multi-cycle with done on the 4th WAIT cycle, which is also the expiry cycle.
    cyc(0,1,0,0,0,0,0, F,0,0,0,0, 4'd3);
    cyc(1,0,0,0,0,0,0, D,0,0,0,0, 4'd3);
    cyc(0,0,0,0,0,0,0, Z,1,0,0,0, 4'd3);
    cyc(0,0,0,0,0,0,0, Z,0,0,0,0, 4'd3);
    cyc(0,0,0,0,0,0,0, Z,0,0,0,0, 4'd3);
    cyc(0,1,0,0,0,0,0, Z,0,0,0,0, 4'd3);
    cyc(0,0,0,0,0,0,0, E,0,0,0,0, 4'd3);

    // Earliest done: one WAIT cycle.
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd4);
    cyc(1,0,0,0,0,0,0, D,0,0,0,0, 4'd4);
    cyc(0,1,0,0,0,0,0, Z,1,0,0,0, 4'd4);
    cyc(0,0,0,0,0,0,0, E,0,0,0,0, 4'd4);

    // HALT instruction; a stray done in DECODE is ignored.
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd5);
    cyc(0,1,0,0,0,0,0, D,0,0,0,0, 4'd5);
    cyc(0,0,1,0,0,0,0, E,0,0,0,0, 4'd5);
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,0,0,0, Z,0,1,0,0, 4'd6);
    cyc(0,0,0,0,0,1,0, Z,0,1,0,0, 4'd6);

    // Branch qualification.
    cyc(0,0,0,1,1,0,0, F,0,0,0,0, 4'd6);
    cyc(0,0,0,1,1,0,0, D,0,0,0,0, 4'd6);
    cyc(0,0,0,1,1,0,0, E,0,0,0,1, 4'd6);
    cyc(0,0,0,1,0,0,0, F,0,0,0,0, 4'd7);
    cyc(0,0,0,1,0,0,0, D,0,0,0,0, 4'd7);
    cyc(0,0,0,1,0,0,0, E,0,0,0,0, 4'd7);
    cyc(0,0,0,0,1,0,0, F,0,0,0,0, 4'd8);
    cyc(0,0,0,0,1,0,0, D,0,0,0,0, 4'd8);
    cyc(0,0,0,0,1,0,0, E,0,0,0,0, 4'd8);

    // Run the retired counter up to all-ones and past it.
    for (int i = 9; i < 16; i++) begin
      cyc(0,0,0,1,1,0,0, F,0,0,0,0, 4'(i));
      cyc(0,0,0,1,1,0,0, D,0,0,0,0, 4'(i));
      cyc(0,0,0,1,1,0,0, E,0,0,0,1, 4'(i));
    end

    // Timeout: four WAIT cycles without done give a fault, and resume is ignored.
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd0);
    cyc(1,0,0,0,0,0,0, D,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, Z,1,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, Z,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, Z,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, Z,0,0,0,0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0,1,0, Z,0,1,1,0, 4'd0);
    cyc(0,0,0,0,0,0,1, Z,0,1,1,0, 4'd0);

    // Reset clears everything; reset in the middle of WAIT abandons the start.
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd0);
    cyc(1,0,0,0,0,0,0, D,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,1, Z,1,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, D,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, E,0,0,0,0, 4'd0);
    cyc(0,0,0,0,0,0,0, F,0,0,0,0, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
